// File: rtl/cam_capture_binarize.sv
// cam_capture_binarize
//   Captures a DVP-style camera byte stream, extracts the luma byte of each
//   pixel, optionally decimates in both axes, thresholds luma to one bit and
//   emits a bitmap write stream. It also checks frame geometry.
//
// Ports
//   cam_pclk    : sole clock, rising edge
//   reset       : synchronous, active-high
//   cam_vsync   : high = idle, low = frame active
//   cam_href    : high = valid byte on cam_data
//   cam_data    : pixel byte stream
//   threshold   : binarisation level (quasi-static)
//   invert      : 1 = invert the binarised bit
//   capture_en  : frame arm enable, sampled at the vsync falling edge
//   wr_addr     : bitmap write address (registered, holds when wr_en=0)
//   wr_data     : binarised pixel (registered, holds when wr_en=0)
//   wr_en       : one-cycle write strobe
//   frame_done  : one-cycle pulse at the end of an armed frame
//   frame_ok    : geometry result, updated together with frame_done
//   dbg_state   : current FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshake: the write port is a fire-and-forget strobe with no ready. When
// wr_en=1, the wr_addr/wr_data pair is valid for exactly that cycle.
module cam_capture_binarize #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int BPP      = 2,
  parameter int LUMA_IDX = 0,
  parameter int DECIM    = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              cam_pclk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic [7:0]        threshold,
  input  logic              invert,
  input  logic              capture_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              dbg_state
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam int PH_W  = (BPP > 1) ? $clog2(BPP) : 1;

  localparam logic [COL_W-1:0]  H_MAX    = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0]  V_MAX    = ROW_W'(V_ACTIVE);
  localparam logic [COL_W-1:0]  COL_MASK = COL_W'(DECIM - 1);
  localparam logic [ROW_W-1:0]  ROW_MASK = ROW_W'(DECIM - 1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(BPP - 1);
  localparam logic [PH_W-1:0]   PH_LUMA  = PH_W'(LUMA_IDX);
  localparam logic [ADDR_W-1:0] LAST_A   =
    ADDR_W'((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM) - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              vs_d1_q, vs_d1_d;
  logic              hr_d1_q, hr_d1_d;
  logic [7:0]        dat_d1_q, dat_d1_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_ok_q, frame_ok_d;

  // Edge detects compare the live pin against its registered copy, so an
  // edge is acted on in the same cycle the delayed copy still shows the old level.
  logic vsync_fall, vsync_rise, href_fall;
  assign vsync_fall = !cam_vsync &&  vs_d1_q;
  assign vsync_rise =  cam_vsync && !vs_d1_q;
  assign href_fall  = !cam_href  &&  hr_d1_q;

  always_comb begin
    state_d      = state_q;
    vs_d1_d      = cam_vsync;
    hr_d1_d      = cam_href;
    dat_d1_d     = cam_data;
    phase_d      = phase_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    err_d        = err_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;

    if (vsync_fall) begin
      // Frame start, also allowed as a mid-frame restart.
      state_d = capture_en ? ACTIVE : IDLE;
      phase_d = '0;
      col_d   = '0;
      row_d   = '0;
      addr_d  = '0;
      err_d   = 1'b0;
    end else if (vsync_rise) begin
      if (state_q == ACTIVE) begin
        frame_done_d = 1'b1;
        frame_ok_d   = (row_q == V_MAX) && !err_q;
      end
      state_d = IDLE;
    end else if (state_q == ACTIVE) begin
      if (hr_d1_q) begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (phase_q == PH_LUMA) begin
          if ((col_q < H_MAX) && (row_q < V_MAX) &&
              ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0)) begin
            wr_en_d   = 1'b1;
            wr_data_d = (dat_d1_q > threshold) ^ invert;
            wr_addr_d = addr_q;
            if (addr_q != LAST_A) addr_d = addr_q + 1'b1;
          end
          // Column saturates, so a luma past the end marks the line as long.
          if (col_q < H_MAX) col_d = col_q + 1'b1;
          else               err_d = 1'b1;
        end
      end
      // The last byte of a line and href_fall land in the same cycle.
      // The capture above is applied first, so col_d includes that byte.
      if (href_fall) begin
        if (col_d != H_MAX) err_d = 1'b1;
        phase_d = '0;
        col_d   = '0;
        if (row_q < V_MAX) row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (reset) begin
      state_q      <= IDLE;
      vs_d1_q      <= 1'b1;
      hr_d1_q      <= 1'b0;
      dat_d1_q     <= '0;
      phase_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_d1_q      <= vs_d1_d;
      hr_d1_q      <= hr_d1_d;
      dat_d1_q     <= dat_d1_d;
      phase_q      <= phase_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cam_capture_binarize.sv
// Bench for cam_capture_binarize: two instances sharing one stimulus stream,
// u_dut1 (DECIM=1, ADDR_W=3) and u_dut2 (DECIM=2, ADDR_W=1), both with H=4, V=2, BPP=2.
module tb_cam_capture_binarize;

  localparam int H = 4;
  localparam int V = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset = 1'b1;
  logic       cam_vsync = 1'b1, cam_href = 1'b0;
  logic [7:0] cam_data = '0, threshold = 8'd128;
  logic       invert = 1'b0, capture_en = 1'b1;

  logic [2:0] wr_addr1;
  logic       wr_data1, wr_en1, frame_done1, frame_ok1, dbg1;
  logic [0:0] wr_addr2;
  logic       wr_data2, wr_en2, frame_done2, frame_ok2, dbg2;

  cam_capture_binarize #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(2), .LUMA_IDX(0),
                         .DECIM(1), .ADDR_W(3)) u_dut1 (
    .cam_pclk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .threshold(threshold), .invert(invert),
    .capture_en(capture_en), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_en(wr_en1), .frame_done(frame_done1), .frame_ok(frame_ok1),
    .dbg_state(dbg1));

  cam_capture_binarize #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(2), .LUMA_IDX(0),
                         .DECIM(2), .ADDR_W(1)) u_dut2 (
    .cam_pclk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .threshold(threshold), .invert(invert),
    .capture_en(capture_en), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .wr_en(wr_en2), .frame_done(frame_done2), .frame_ok(frame_ok2),
    .dbg_state(dbg2));

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp1_addr_q[$];
  logic       exp1_data_q[$];
  int         exp1_cyc_q[$];
  logic [0:0] exp2_addr_q[$];
  logic       exp2_data_q[$];
  int         exp2_cyc_q[$];
  logic       exp1_ok_q[$];
  logic       exp2_ok_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitors: outputs change on posedge, sampled on negedge
  always @(negedge clk) begin
    if (wr_en1) begin
      check("dut1_wr_expected", 32'(exp1_addr_q.size() > 0), 1);
      if (exp1_addr_q.size() > 0) begin
        check("dut1_wr_addr", wr_addr1, exp1_addr_q.pop_front());
        check("dut1_wr_data", wr_data1, exp1_data_q.pop_front());
        check("dut1_wr_latency", cyc, exp1_cyc_q.pop_front());
      end
    end
    if (wr_en2) begin
      check("dut2_wr_expected", 32'(exp2_addr_q.size() > 0), 1);
      if (exp2_addr_q.size() > 0) begin
        check("dut2_wr_addr", wr_addr2, exp2_addr_q.pop_front());
        check("dut2_wr_data", wr_data2, exp2_data_q.pop_front());
        check("dut2_wr_latency", cyc, exp2_cyc_q.pop_front());
      end
    end
    if (frame_done1) begin
      check("dut1_done_expected", 32'(exp1_ok_q.size() > 0), 1);
      if (exp1_ok_q.size() > 0) check("dut1_frame_ok", frame_ok1, exp1_ok_q.pop_front());
    end
    if (frame_done2) begin
      check("dut2_done_expected", 32'(exp2_ok_q.size() > 0), 1);
      if (exp2_ok_q.size() > 0) check("dut2_frame_ok", frame_ok2, exp2_ok_q.pop_front());
    end
  end

  // driver
  logic [7:0] ypix[0:3][0:7];
  int         line_len[0:3];
  int         a1, a2;

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    @(negedge clk);
  endtask

  // Push the expected write for luma pixel p of line r. It is driven now,
  // sampled at the next edge and observed two negedges from now.
  task automatic push_pixel(input int r, input int p, input logic [7:0] y);
    logic bit_v;
    bit_v = (y > threshold) ^ invert;
    if (p < H && r < V) begin
      exp1_addr_q.push_back(3'(a1));
      exp1_data_q.push_back(bit_v);
      exp1_cyc_q.push_back(cyc + 2);
      if (a1 < 7) a1++;
      if (p % 2 == 0 && r % 2 == 0) begin
        exp2_addr_q.push_back(1'(a2));
        exp2_data_q.push_back(bit_v);
        exp2_cyc_q.push_back(cyc + 2);
        if (a2 < 1) a2++;
      end
    end
  endtask

  task automatic send_frame(input int nlines, input bit arm, input bit term_last,
                            input logic [7:0] thr, input bit inv);
    int  rows;
    bit  err;
    threshold  = thr;
    invert     = inv;
    capture_en = arm;
    rows = 0;
    err  = 1'b0;
    a1   = 0;
    a2   = 0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int r = 0; r < nlines; r++) begin
      for (int p = 0; p < line_len[r]; p++) begin
        if (arm) push_pixel(r, p, ypix[r][p]);
        step(1'b0, 1'b1, ypix[r][p]);
        step(1'b0, 1'b1, 8'(8'h5A ^ p));
      end
      if (r != nlines - 1 || term_last) begin
        if (line_len[r] != H) err = 1'b1;
        if (rows < V) rows++;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
      end
    end
    if (arm) begin
      exp1_ok_q.push_back((rows == V) && !err);
      exp2_ok_q.push_back((rows == V) && !err);
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic load_base;
    ypix[0][0] = 8'd10;  ypix[0][1] = 8'd200; ypix[0][2] = 8'd90;  ypix[0][3] = 8'd130;
    ypix[1][0] = 8'd0;   ypix[1][1] = 8'd255; ypix[1][2] = 8'd128; ypix[1][3] = 8'd129;
    ypix[1][4] = 8'd250; ypix[1][5] = 8'd251;
    line_len[0] = 4;
    line_len[1] = 4;
  endtask

  initial begin
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en1, 0);
    check("rst_wr_addr", wr_addr1, 0);
    check("rst_wr_data", wr_data1, 0);
    check("rst_frame_done", frame_done1, 0);
    check("rst_frame_ok", frame_ok1, 0);
    check("rst_state", dbg1, 0);
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h00);

    // basic frame
    load_base();
    send_frame(2, 1'b1, 1'b1, 8'd128, 1'b0);
    check("hold_wr_en", wr_en1, 0);
    check("hold_wr_addr", wr_addr1, 7);
    check("hold_wr_data", wr_data1, 1);
    check("hold_frame_ok", frame_ok1, 1);
    check("idle_state", dbg1, 0);

    // inverted
    send_frame(2, 1'b1, 1'b1, 8'd128, 1'b1);

    // short second line, then long second line
    line_len[1] = 3;
    send_frame(2, 1'b1, 1'b1, 8'd128, 1'b0);
    line_len[1] = 6;
    send_frame(2, 1'b1, 1'b1, 8'd128, 1'b0);
    check("long_line_frame_ok", frame_ok1, 0);

    // all Y=200, threshold 0: decimated instance writes 2 pixels
    load_base();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) ypix[r][p] = 8'd200;
    send_frame(2, 1'b1, 1'b1, 8'd0, 1'b0);

    // threshold 255 never exceeded, even with Y=255
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) ypix[r][p] = 8'(r * 4 + p == 0 ? 255 : $urandom_range(0, 255));
    send_frame(2, 1'b1, 1'b1, 8'd255, 1'b0);
    check("thr255_last_data", wr_data1, 0);

    // unarmed frame: nothing, frame_ok keeps its value
    send_frame(2, 1'b0, 1'b1, 8'd128, 1'b0);
    check("unarmed_frame_ok_hold", frame_ok1, 1);
    check("unarmed_wr_addr_hold", wr_addr1, 7);

    // random content and threshold
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) ypix[r][p] = 8'($urandom_range(0, 255));
    send_frame(2, 1'b1, 1'b1, 8'($urandom_range(1, 254)), 1'($urandom_range(0, 1)));

    // final line not terminated before vsync rises
    load_base();
    send_frame(2, 1'b1, 1'b0, 8'd128, 1'b0);
    check("unterminated_frame_ok", frame_ok1, 0);

    // good frame, then reset mid-frame after 3 writes
    send_frame(2, 1'b1, 1'b1, 8'd128, 1'b1);
    invert = 1'b1;
    a1 = 0;
    a2 = 0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("mid_frame_state", dbg1, 1);
    for (int p = 0; p < 3; p++) begin
      push_pixel(0, p, ypix[0][p]);
      step(1'b0, 1'b1, ypix[0][p]);
      step(1'b0, 1'b1, 8'h11);
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("pre_rst_wr_addr", wr_addr1, 2);
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    check("mid_rst_wr_en", wr_en1, 0);
    check("mid_rst_wr_addr", wr_addr1, 0);
    check("mid_rst_wr_data", wr_data1, 0);
    check("mid_rst_frame_ok", frame_ok1, 0);
    check("mid_rst_state", dbg1, 0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    repeat (4) step(1'b1, 1'b0, 8'h00);

    // next frame restarts at address 0
    send_frame(2, 1'b1, 1'b1, 8'd128, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'h00);

    check("dut1_wr_queue_empty", exp1_addr_q.size(), 0);
    check("dut2_wr_queue_empty", exp2_addr_q.size(), 0);
    check("dut1_done_queue_empty", exp1_ok_q.size(), 0);
    check("dut2_done_queue_empty", exp2_ok_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
